// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, controller state type and alignment check for the LSU bus controller
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'b00);
    endfunction

endpackage

// File: rtl/store_aligner.sv
// store_aligner: places store data on the byte lanes selected by access size and offset
module store_aligner
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    assign wstrb = funct3 == F3_SB ? 4'b0001 << off : funct3 == F3_SH ? 4'b0011 << off : 4'b1111;
    assign wdata = funct3 == F3_SB ? {4{data[7:0]}} : funct3 == F3_SH ? {2{data[15:0]}} : data;

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: turns core load/store requests into valid/ready bus transactions and stalls the core until done
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata_in,
    input  logic [2:0]        funct3,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rd_word,
    output logic [1:0]        byte_offset,
    output logic [2:0]        ld_funct3,
    output logic              misaligned,
    output logic              access_fault,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t    state, state_next;
    logic [CW-1:0] cnt;
    logic          req, wr, bad, tmo;
    logic [3:0]    st_wstrb;
    logic [31:0]   st_wdata;

    assign req   = mem_read | mem_write;
    assign wr    = mem_write & ~mem_read;
    assign bad   = is_misaligned(funct3, addr[1:0]) |
                   (wr ? !(funct3 inside {F3_SB, F3_SH, F3_SW})
                       : !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}));
    assign tmo   = (TIMEOUT_CYCLES != 0) && (cnt + CW'(1) == CW'(TIMEOUT_CYCLES));
    assign stall = req && state != DONE;

    store_aligner u_store_aligner (
        .funct3 (funct3),
        .off    (addr[1:0]),
        .data   (wdata_in),
        .wstrb  (st_wstrb),
        .wdata  (st_wdata)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next state; a response arriving in the timeout cycle still completes normally
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = req ? (bad ? DONE : REQ) : IDLE;
            REQ:       state_next = bus_ready ? (bus_we ? DONE : WAIT_RESP) : (tmo ? DONE : REQ);
            WAIT_RESP: state_next = (bus_rvalid || tmo) ? DONE : WAIT_RESP;
            default:   state_next = IDLE;
        endcase
    end

    // bus request, captured load context, fault flags and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done         <= 1'b0;
            rd_word      <= '0;
            byte_offset  <= '0;
            ld_funct3    <= '0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            bus_valid    <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wstrb    <= '0;
            bus_wdata    <= '0;
            cnt          <= '0;
        end else begin
            done <= state_next == DONE;
            case (state)
                IDLE: if (req) begin
                    byte_offset <= addr[1:0];
                    ld_funct3   <= funct3;
                    misaligned  <= bad;
                    bus_valid   <= !bad;
                    bus_we      <= wr;
                    bus_addr    <= {addr[ADDR_W-1:2], 2'b00};
                    bus_wstrb   <= wr ? st_wstrb : 4'b0000;
                    bus_wdata   <= st_wdata;
                    cnt         <= '0;
                end
                REQ: begin
                    cnt          <= cnt + CW'(1);
                    bus_valid    <= !(bus_ready || tmo);
                    access_fault <= !bus_ready && tmo;
                end
                WAIT_RESP: begin
                    cnt          <= cnt + CW'(1);
                    access_fault <= !bus_rvalid && tmo;
                    if (bus_rvalid) rd_word <= bus_rdata;
                end
                default: begin
                    misaligned   <= 1'b0;
                    access_fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed and randomized accesses checked against a transaction-level model
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata_in;
    logic [2:0]  funct3;
    logic        stall, done;
    logic [31:0] rd_word;
    logic [1:0]  byte_offset;
    logic [2:0]  ld_funct3;
    logic        misaligned, access_fault;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rd = '0;

    int          op, r_rdly, r_rvdly;
    bit          r_rd, r_wr, r_resp, r_hold;
    logic [31:0] r_a, r_d, r_rdata;
    logic [2:0]  r_f3;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr         (addr),
        .wdata_in     (wdata_in),
        .funct3       (funct3),
        .stall        (stall),
        .done         (done),
        .rd_word      (rd_word),
        .byte_offset  (byte_offset),
        .ld_funct3    (ld_funct3),
        .misaligned   (misaligned),
        .access_fault (access_fault),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cleared(input string pre);
        check({pre, "_done"}, done, 0);
        check({pre, "_rd_word"}, rd_word, 0);
        check({pre, "_byte_offset"}, byte_offset, 0);
        check({pre, "_ld_funct3"}, ld_funct3, 0);
        check({pre, "_flags"}, {misaligned, access_fault}, 0);
        check({pre, "_bus_valid"}, bus_valid, 0);
        check({pre, "_bus_we"}, bus_we, 0);
        check({pre, "_bus_addr"}, bus_addr, 0);
        check({pre, "_bus_wstrb"}, bus_wstrb, 0);
        check({pre, "_bus_wdata"}, bus_wdata, 0);
    endtask

    // one core access; the model predicts latency, bus fields and results from the access rules
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input int rdly, input int rvdly, input bit respond,
                          input logic [31:0] rdata, input bit hold);
        bit          is_ld    = rd;
        int          bytes    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bit          illegal  = is_ld ? (f3 == 3'd3 || f3 >= 3'd6) : (f3 >= 3'd3);
        bit          bad      = illegal || (a % bytes) != 0;
        bit          tmo      = !bad && (rdly >= 4 || (is_ld && !respond));
        int          lat      = bad ? 1 : tmo ? 5 : is_ld ? rdly + rvdly + 3 : rdly + 2;
        int          exp_v    = bad ? 0 : (rdly >= 4) ? 4 : rdly + 1;
        logic [3:0]  exp_strb = is_ld ? 4'd0 : 4'(((1 << bytes) - 1) << a[1:0]);
        logic [31:0] exp_wd   = bytes == 1 ? d[7:0] * 32'h01010101 : bytes == 2 ? d[15:0] * 32'h00010001 : d;
        int          cyc = 0, vcyc = 0, acc = -1, stalls = 0;
        bit          got = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata_in = d; funct3 = f3;
        while (!got && cyc < 30) begin
            #1;
            bus_ready = 0; bus_rvalid = 0;
            if (done) begin
                got = 1;
                check("latency", cyc, lat);
                check("stall_cycles", stalls, lat);
                check("stall_at_done", stall, 0);
                check("valid_cycles", vcyc, exp_v);
                check("misaligned", misaligned, bad);
                check("access_fault", access_fault, tmo);
                if (is_ld && !bad && !tmo) exp_rd = rdata;
                check("rd_word", rd_word, exp_rd);
                check("byte_offset", byte_offset, a[1:0]);
                check("ld_funct3", ld_funct3, f3);
            end else begin
                stalls += int'(stall);
                if (bus_valid) begin
                    check("bus_addr", bus_addr, a & ~32'h3);
                    check("bus_we", bus_we, !is_ld);
                    check("bus_wstrb", bus_wstrb, exp_strb);
                    if (!is_ld) check("bus_wdata", bus_wdata, exp_wd);
                    if (vcyc == rdly) begin bus_ready = 1; acc = cyc; end
                    vcyc++;
                end
                if (is_ld && respond && acc >= 0 && cyc == acc + 1 + rvdly) begin
                    bus_rvalid = 1;
                    bus_rdata  = rdata;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) check("done_seen", 0, 1);
        if (!hold) begin
            mem_read = 0; mem_write = 0;
            @(negedge clk); #1;
            check("idle_done", done, 0);
            check("idle_stall", stall, 0);
            check("idle_flags", {misaligned, access_fault}, 0);
            check("idle_valid", bus_valid, 0);
        end
    endtask

    initial begin
        rst_n = 0; mem_read = 0; mem_write = 0; addr = 0; wdata_in = 0; funct3 = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        #1;
        check_cleared("reset");
        check("reset_stall", stall, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        access(1, 0, 32'h100, 0, 3'b010, 0, 0, 1, 32'hDEADBEEF, 0);
        access(0, 1, 32'h203, 32'h000000A5, 3'b000, 2, 0, 1, 0, 0);
        access(0, 1, 32'h2, 32'h1234, 3'b001, 0, 0, 1, 0, 0);
        access(1, 0, 32'h3, 0, 3'b001, 0, 0, 1, 0, 0);
        access(1, 0, 32'h101, 0, 3'b100, 0, 0, 0, 0, 0);
        access(0, 1, 32'h8, 32'h55, 3'b010, 99, 0, 1, 0, 0);
        access(1, 1, 32'h22, 32'hFFFF, 3'b101, 1, 0, 1, 32'h0BADF00D, 0);
        access(0, 1, 32'h4, 32'h1, 3'b011, 0, 0, 1, 0, 0);
        access(1, 0, 32'h4, 0, 3'b110, 0, 0, 1, 0, 0);

        // reset while waiting for a load response; the late response must be ignored
        @(negedge clk);
        mem_read = 1; addr = 32'h43; funct3 = 3'b100;
        @(negedge clk); #1; bus_ready = 1;
        @(negedge clk); #1; bus_ready = 0;
        check("wait_valid_low", bus_valid, 0);
        check("wait_stall", stall, 1);
        check("pre_rst_off", byte_offset, 2'd3);
        rst_n = 0; #1;
        check_cleared("rst_wait");
        mem_read = 0; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("late_rvalid_done", done, 0);
            check("late_rvalid_rd", rd_word, 0);
            check("late_rvalid_stall", stall, 0);
            bus_rvalid = 0;
        end
        exp_rd = 0;

        // reset while the request is on the bus drops bus_valid at once
        @(negedge clk);
        mem_write = 1; addr = 32'h80; wdata_in = 32'h77; funct3 = 3'b010;
        @(negedge clk); #1;
        check("req_valid_high", bus_valid, 1);
        rst_n = 0; #1;
        check("rst_req_valid", bus_valid, 0);
        mem_write = 0;
        @(negedge clk); rst_n = 1;

        access(1, 0, 32'h10, 0, 3'b010, 0, 0, 1, 32'h11111111, 1);
        access(1, 0, 32'h14, 0, 3'b010, 0, 1, 1, 32'h22222222, 0);

        for (int i = 0; i < 80; i++) begin
            op      = $urandom_range(0, 2);
            r_rd    = op != 1;
            r_wr    = op != 0;
            r_a     = $urandom;
            if ($urandom_range(0, 1) == 0) r_a = r_a & ~32'h3;
            r_d     = $urandom;
            r_rdata = $urandom;
            r_f3    = 3'($urandom_range(0, 7));
            r_hold  = $urandom_range(0, 3) == 0;
            if (r_rd) begin
                r_rdly  = $urandom_range(0, 1);
                r_rvdly = r_rdly != 0 ? 0 : $urandom_range(0, 1);
                r_resp  = $urandom_range(0, 7) != 0;
            end else begin
                r_rdly  = $urandom_range(0, 7) == 0 ? 99 : $urandom_range(0, 2);
                r_rvdly = 0;
                r_resp  = 1;
            end
            access(r_rd, r_wr, r_a, r_d, r_f3, r_rdly, r_rvdly, r_resp, r_rdata, r_hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
